// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the display scheduler slice.
// Provides the result data width, the default channel count and the
// scheduler FSM state type.
package display_pkg;

  localparam int DATA_W     = 8;
  localparam int NUM_CH_DEF = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/rr_next_filled.sv
// rr_next_filled: combinational round-robin search for the next filled slot.
// Ports: filled (slot occupancy), cur (current index) -> nxt (first filled
// index strictly after cur, modulo NUM_CH; cur if none), found (one was hit).
module rr_next_filled #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] filled,
  input  logic [IDX_W-1:0]  cur,
  output logic [IDX_W-1:0]  nxt,
  output logic              found
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest
  // filled slot after cur is the one left standing.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      idx = IDX_W'((int'(cur) + k) % NUM_CH);
      if (filled[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: time-multiplexes per-channel 8-bit results onto one
// display value, rotating round-robin over filled slots with a fixed dwell.
// Ports: clk/rstb, res_valid/res_data (channel capture), pause/next (buttons),
// convolution/ch_sel/disp_valid (registered display outputs).
module display_scheduler
  import display_pkg::*;
#(
  parameter  int NUM_CH      = NUM_CH_DEF,
  parameter  int HOLD_CYCLES = 50_000_000,
  localparam int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W       = $clog2(HOLD_CYCLES)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [NUM_CH-1:0]        res_valid,
  input  logic [NUM_CH*DATA_W-1:0] res_data,
  input  logic                     pause,
  input  logic                     next,
  output logic [DATA_W-1:0]        convolution,
  output logic [IDX_W-1:0]         ch_sel,
  output logic                     disp_valid
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

  logic [NUM_CH-1:0][DATA_W-1:0] slot_q, slot_d;
  logic [NUM_CH-1:0]             filled_q, filled_d;
  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              cur_q, cur_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]             conv_q;
  logic [IDX_W-1:0]              ch_sel_q;
  logic                          disp_valid_q;

  logic [IDX_W-1:0] lo_nxt, adv_nxt;
  logic             lo_found, adv_found;
  logic             advance;

  // Searches run on filled_d so a slot captured this cycle can be picked.
  // Starting from the last index makes the search return the lowest one.
  rr_next_filled #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_lowest (
    .filled (filled_d),
    .cur    (LAST),
    .nxt    (lo_nxt),
    .found  (lo_found)
  );

  rr_next_filled #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_advance (
    .filled (filled_d),
    .cur    (cur_q),
    .nxt    (adv_nxt),
    .found  (adv_found)
  );

  // next overrides pause; terminal count together with next is one advance.
  assign advance = next | ((cnt_q == TERM) & ~pause);

  always_comb begin
    filled_d = filled_q | res_valid;
    slot_d   = slot_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (res_valid[i]) slot_d[i] = res_data[i*DATA_W +: DATA_W];
    end
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|filled_d) begin
          state_d = SHOW;
          cur_d   = lo_found ? lo_nxt : LAST;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (advance) begin
          cur_d = adv_found ? adv_nxt : cur_q;
          cnt_d = '0;
        end else if (!pause) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      slot_q       <= '0;
      filled_q     <= '0;
      state_q      <= IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      conv_q       <= '0;
      ch_sel_q     <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      filled_q     <= filled_d;
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      // Output stage samples the committed selection, so ch_sel and
      // convolution always move together one edge after the decision.
      conv_q       <= (state_q == SHOW) ? slot_q[cur_q] : '0;
      ch_sel_q     <= cur_q;
      disp_valid_q <= (state_q == SHOW);
    end
  end

  assign convolution = conv_q;
  assign ch_sel      = ch_sel_q;
  assign disp_valid  = disp_valid_q;

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-multiplexes the 8-bit results of several convolution channels onto the single `convolution` input of the 7-segment display path. Each channel's latest result is held in its own slot. The block then rotates round-robin through the filled slots, showing each one for a fixed dwell time. Pause and manual-advance controls come from board buttons. It sits between the convolution engines and the display top level, and drives the display's value input plus a channel indicator.

## Interface

Parameters:
- `NUM_CH`, 4: number of result channels, 2..8.
- `HOLD_CYCLES`, 50_000_000: dwell per channel in clk cycles (1 s at 50 MHz); must be ≥ 2.

Ports:
- `clk` input 1: single system clock; all state is on the rising edge.
- `rstb` input 1: reset, asynchronous, active-high (1 = reset asserted).
- `res_valid` input NUM_CH: one-cycle strobe per channel; bit i qualifies slot i data.
- `res_data` input NUM_CH*8: channel i result on bits [8i+7:8i], unsigned.
- `pause` input 1: level; while 1 the dwell counter is frozen.
- `next` input 1: single-cycle pulse (already debounced and edge-detected upstream); forces an advance.
- `convolution` output 8: value for the display path; registered.
- `ch_sel` output max(1,$clog2(NUM_CH)): index of the slot being shown; registered.
- `disp_valid` output 1: 1 when `convolution` holds real slot data; registered.

## Operation

- Slots: `slot[i]` is 8 bits, `filled[i]` is 1 bit. A `res_valid[i]` strobe writes `res_data[i]` into `slot[i]` and sets `filled[i]`. Simultaneous strobes on several channels are all captured in the same cycle. A new strobe on a filled slot overwrites it. `filled` bits are cleared only by reset.
- FSM states:
  - IDLE: no slot filled. Outputs `convolution`=0, `ch_sel`=0, `disp_valid`=0.
    - Exits to SHOW when any `filled` bit would be set at the next edge.
    - `ch_sel` takes the lowest filled index, and the counter loads 0.
  - SHOW: shows the current slot.
    - `convolution` tracks `slot[ch_sel]`. A rewrite of the current slot is shown one cycle after its capture.
    - Dwell counter: width $clog2(HOLD_CYCLES). It increments each cycle while `pause`=0 and holds while `pause`=1.
    - Advance happens on (counter == HOLD_CYCLES-1 and `pause`=0) or on `next`=1. `next` overrides `pause`.
    - On advance, `ch_sel` moves to the next filled index strictly after the current one, wrapping modulo NUM_CH. If no other slot is filled it stays on the current one. The counter reloads 0 in both cases.
- SHOW never returns to IDLE; only reset does that.
- Terminal count and `next` in the same cycle produce a single advance.
- A capture into a slot that is currently unfilled, in the same cycle as an advance, is eligible as the advance target.

## Timing

- Reset values: `convolution`=0, `ch_sel`=0, `disp_valid`=0, all `slot`/`filled`=0, counter=0, FSM=IDLE.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first capture after release follows the IDLE→SHOW rule.
- Capture latency: a strobe at edge N appears on `convolution` at edge N+1 if that slot is shown. The first strobe from IDLE sets `disp_valid`=1 at edge N+1.
- Dwell: the slot entered at edge E is shown for exactly HOLD_CYCLES cycles with `pause`=0. The new `ch_sel`/`convolution` appear at edge E+HOLD_CYCLES.
- `next` at edge N updates the outputs at edge N+1.
- `ch_sel` and `convolution` always change on the same edge; no glitch cycle shows a mismatched pair.

## Structure

- Shared package `display_pkg`:
  - `DATA_W`=8.
  - Default `NUM_CH`.
  - FSM state typedef {IDLE, SHOW}.
- Sub-module `rr_next_filled`: combinational.
  - Inputs: `filled` vector and `cur` index.
  - Outputs: `nxt` index and `found`.
  - Searches cur+1 … cur+NUM_CH-1 modulo NUM_CH; `nxt`=`cur` when nothing else is filled.
  - Also used for the lowest-index pick with cur=NUM_CH-1.
- The top level holds the slot registers, the counter and the FSM.

## Test plan

All scenarios use HOLD_CYCLES=8 and NUM_CH=4.

- Reset then idle for 20 cycles → `disp_valid`=0, `convolution`=0, `ch_sel`=0 throughout.
- Strobe ch2=0x7B at cycle 5 → `disp_valid`=1, `ch_sel`=2, `convolution`=0x7B at cycle 6; unchanged after 8 cycles (single filled slot).
- Fill ch0=10, ch1=20, ch3=30 together → display sequence 0,1,3,0 with each value shown exactly 8 cycles; slot 2 is skipped.
- `pause`=1 for 20 cycles mid-dwell → counter frozen, no advance. Then a `next` pulse during the pause → advance at the following edge.
- Rewrite the shown slot ch1 from 20 to 99 mid-dwell → `convolution`=99 one cycle later, `ch_sel` unchanged, dwell not restarted.
- Assert `rstb` mid-dwell while 3 slots are filled → all outputs 0 immediately; the next strobe on ch3 → `ch_sel`=3.
